// File: rtl/garage_occupancy_counter_pkg.sv
// Shared types, default parameters and BCD helpers for the garage occupancy counter.
package garage_occupancy_counter_pkg;

  localparam int unsigned DEF_CAPACITY  = 20;
  localparam int unsigned DEF_DEBOUNCE  = 4;
  localparam int unsigned DEF_GATE_HOLD = 8;
  localparam int unsigned BCD_W         = 4;
  localparam int unsigned CNT_W         = 8;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    GATE_CLOSED = 1'b0,
    GATE_OPEN   = 1'b1
  } gate_state_e;

  typedef struct packed {
    bcd_t tens;
    bcd_t units;
  } occ_t;

  function automatic occ_t occ_inc(input occ_t o);
    occ_t r;
    r = o;
    if (o.units == BCD_W'(9)) begin
      r.units = '0;
      r.tens  = o.tens + BCD_W'(1);
    end else begin
      r.units = o.units + BCD_W'(1);
    end
    return r;
  endfunction

  function automatic occ_t occ_dec(input occ_t o);
    occ_t r;
    r = o;
    if (o.units == '0) begin
      r.units = BCD_W'(9);
      r.tens  = o.tens - BCD_W'(1);
    end else begin
      r.units = o.units - BCD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/garage_occupancy_counter_sensor_debounce.sv
// Two-flop synchronizer, stability debouncer and rising-edge event for one lane sensor.
module sensor_debounce
  import garage_occupancy_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_i,
  output logic evt_o
);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             prev_q;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips on the DEBOUNCE-th consecutive mismatching sample.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    evt_d   = level_q & ~prev_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], sensor_i};
      level_q <= level_d;
      prev_q  <= level_q;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt_o = evt_q;

endmodule

// File: rtl/garage_occupancy_counter.sv
// Garage occupancy tracker: debounced lane sensors feed a two-digit BCD counter and an
// entry-gate hold FSM.
module garage_occupancy_counter
  import garage_occupancy_counter_pkg::*;
#(
  parameter int unsigned CAPACITY  = DEF_CAPACITY,
  parameter int unsigned DEBOUNCE  = DEF_DEBOUNCE,
  parameter int unsigned GATE_HOLD = DEF_GATE_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic enter_sensor,
  input  logic exit_sensor,
  output bcd_t tens,
  output bcd_t units,
  output logic full,
  output logic empty,
  output logic gate_open,
  output logic reject
);

  localparam bcd_t CAP_TENS  = BCD_W'(CAPACITY / 10);
  localparam bcd_t CAP_UNITS = BCD_W'(CAPACITY % 10);

  logic             enter_evt, exit_evt;
  occ_t             occ_q, occ_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             reject_q, reject_d;
  logic             gate_open_q, gate_open_d;
  gate_state_e      state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             accept;

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_enter (
    .clk      (clk),
    .rst      (rst),
    .sensor_i (enter_sensor),
    .evt_o    (enter_evt)
  );

  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit (
    .clk      (clk),
    .rst      (rst),
    .sensor_i (exit_sensor),
    .evt_o    (exit_evt)
  );

  // Simultaneous enter/exit keeps the count but still lets the entering car through.
  always_comb begin
    occ_d    = occ_q;
    state_d  = state_q;
    hold_d   = hold_q;
    accept   = enter_evt & (exit_evt | ~full_q);
    reject_d = enter_evt & ~exit_evt & full_q;

    if (enter_evt && !exit_evt && !full_q) begin
      occ_d = occ_inc(occ_q);
    end else if (exit_evt && !enter_evt && !empty_q) begin
      occ_d = occ_dec(occ_q);
    end
    full_d  = (occ_d == {CAP_TENS, CAP_UNITS});
    empty_d = (occ_d == '0);

    case (state_q)
      GATE_CLOSED: begin
        if (accept) begin
          state_d = GATE_OPEN;
          hold_d  = CNT_W'(GATE_HOLD);
        end
      end
      GATE_OPEN: begin
        if (accept) begin
          hold_d = CNT_W'(GATE_HOLD);
        end else begin
          hold_d = hold_q - CNT_W'(1);
          if (hold_q == CNT_W'(1)) begin
            state_d = GATE_CLOSED;
          end
        end
      end
      default: state_d = GATE_CLOSED;
    endcase
    gate_open_d = (state_d == GATE_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      reject_q    <= 1'b0;
      state_q     <= GATE_CLOSED;
      hold_q      <= '0;
      gate_open_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      reject_q    <= reject_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      gate_open_q <= gate_open_d;
    end
  end

  assign tens      = occ_q.tens;
  assign units     = occ_q.units;
  assign full      = full_q;
  assign empty     = empty_q;
  assign gate_open = gate_open_q;
  assign reject    = reject_q;

endmodule

// File: doc/garage_occupancy_counter.md
GARAGE_OCCUPANCY_COUNTER -- requirements
Module: garage_occupancy_counter

Interface
REQ-001 Parameter CAPACITY, default 20, is the maximum number of parked cars; the legal range is 1..99.
REQ-002 Parameter DEBOUNCE, default 4, is the number of consecutive stable cycles a synchronized sensor needs to change level; the legal range is 1..255.
REQ-003 Parameter GATE_HOLD, default 8, is the number of cycles gate_open stays high per accepted entry; the legal range is 1..255.
REQ-004 clk  input  1  single system clock; all logic is rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enter_sensor  input  1  raw asynchronous entry-lane car detector; high means a car is present.
REQ-007 exit_sensor  input  1  raw asynchronous exit-lane car detector; high means a car is present.
REQ-008 tens  output  4  BCD tens digit of occupancy; drives the seven-segment decoder num input.
REQ-009 units  output  4  BCD units digit of occupancy; drives a second seven-segment decoder.
REQ-010 full  output  1  high when occupancy equals CAPACITY.
REQ-011 empty  output  1  high when occupancy equals 0.
REQ-012 gate_open  output  1  entry barrier command.
REQ-013 reject  output  1  one-cycle pulse when an entry is refused because the garage is full.

Function
REQ-014 Each sensor SHALL pass through a 2-flop synchronizer and then its own debouncer (a counter and a registered level).
REQ-015 The debouncer counter SHALL clear whenever the synchronized value equals the debounced level; otherwise it counts, and the level SHALL flip once the mismatch has lasted DEBOUNCE cycles.
REQ-016 A 0->1 transition of a debounced level SHALL generate a one-cycle event (enter_evt / exit_evt); 1->0 transitions generate nothing.
REQ-017 Total latency: a sensor held high from edge k SHALL change tens/units/full/empty at edge k+DEBOUNCE+3.
REQ-018 Pulses shorter than DEBOUNCE synchronized cycles SHALL generate no event.
REQ-019 Occupancy SHALL be held directly as two BCD digits and never as a binary value converted to BCD.
REQ-020 Increment: units 9->0 with tens+1; otherwise units+1.
REQ-021 Decrement: units 0->9 with tens-1; otherwise units-1.
REQ-022 enter_evt with full=0 and exit_evt=0 SHALL increment occupancy and start the gate FSM.
REQ-023 enter_evt with full=1 and exit_evt=0 SHALL leave occupancy unchanged, pulse reject in the same cycle the increment would have occurred, and leave the gate closed.
REQ-024 exit_evt with empty=1 and enter_evt=0 SHALL be ignored; occupancy never underflows.
REQ-025 Simultaneous enter_evt and exit_evt SHALL leave occupancy unchanged.
REQ-026 The case in REQ-025 SHALL start the gate FSM, even when full=1, and SHALL NOT pulse reject.
REQ-027 full and empty SHALL be registered and valid in the same cycle as the digits they describe.
REQ-028 Gate FSM states: CLOSED, OPEN.
REQ-029 CLOSED->OPEN on an accepted entry, loading a hold counter with GATE_HOLD; gate_open is high only in OPEN.
REQ-030 In OPEN the hold counter SHALL decrement each cycle, and the FSM SHALL go OPEN->CLOSED when the counter reaches 0.
REQ-031 An accepted entry while in OPEN SHALL reload the hold counter with GATE_HOLD.
REQ-032 tens SHALL never exceed 9, units SHALL never exceed 9, and occupancy SHALL never exceed CAPACITY.

Reset
REQ-033 While rst=1, at every rising clk: synchronizers, debounced levels and debounce counters = 0; tens = units = 0; empty = 1; full = 0; gate FSM = CLOSED; gate_open = 0; reject = 0.
REQ-034 Reset asserted mid-debounce or mid-gate-hold SHALL abort that operation with no event emitted.
REQ-035 A sensor already high when rst deasserts SHALL be debounced and counted as a fresh arrival.

Structure
REQ-036 A shared package SHALL hold the gate-state enum, the BCD digit type (4 bits), and the default CAPACITY, DEBOUNCE and GATE_HOLD constants.
REQ-037 The synchronizer plus debouncer plus edge detector SHALL be one sub-module, sensor_debounce, instantiated twice.
REQ-038 The BCD counter and gate FSM SHALL remain in the top module.

Verification (DEBOUNCE=4, GATE_HOLD=8, CAPACITY=20 unless noted)
REQ-039 Reset, then enter_sensor high at edge 10 -> tens/units go 0/0 -> 0/1 at edge 17; empty 1 -> 0; gate_open high for exactly 8 cycles.
REQ-040 enter_sensor pulses of 3 cycles, repeated 5 times -> occupancy stays 00 and no gate_open.
REQ-041 9 entries -> 0/9; one more entry -> 1/0; one exit -> 0/9; 10 exits -> 00 with empty=1 and no underflow on the extra exit.
REQ-042 CAPACITY=15, 15 entries -> 1/5 with full=1; a 16th entry -> reject pulses once, digits stay 1/5, gate_open stays low.
REQ-043 With occupancy 0/7, both sensors rise on the same edge -> digits stay 0/7, gate_open pulses, reject stays 0.
REQ-044 rst asserted 2 cycles into a gate hold, with enter_sensor mid-debounce -> gate_open low at the next edge, digits 0/0, and no count once rst is released until the sensor re-stabilises (REQ-035).
